input_conditioner: RTL

Upstream front-end for the turn-signal/hazard FSM. It synchronises and debounces the board pushbuttons (KEY, active-low) and slide switches (SW) on the 10 MHz board clock. It then presents clean levels and single-cycle edge pulses to the next-state logic and counter. The FSM's next-state logic takes only conditioned inputs from this block, never raw pins.

---
 rtl/input_conditioner.sv | 103 ++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Synchronises and debounces pushbuttons (active-low) and slide switches, giving
// clean active-high levels plus single-cycle press/release/change pulses.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int NUM_KEYS        = 2,
    parameter int NUM_SW          = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic [NUM_SW-1:0]   sw_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_SW-1:0]   sw_level,
    output logic                sw_change
);
    localparam int N  = NUM_KEYS + NUM_SW;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // Idle value of the synchroniser; XOR with it also turns active-low keys into active-high.
    localparam logic [N-1:0] SYNC_IDLE = {{NUM_SW{1'b0}}, {NUM_KEYS{1'b1}}};

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } chan_state_t;

    logic [N-1:0]  sync1_q, sync2_q, synced;
    logic [N-1:0]  level_q, level_d, toggle;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];
    chan_state_t   state_q [N];
    chan_state_t   state_d [N];

    logic [NUM_KEYS-1:0] press_q, release_q;
    logic                change_q;

    assign synced = sync2_q ^ SYNC_IDLE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= SYNC_IDLE;
            sync2_q <= SYNC_IDLE;
        end else begin
            sync1_q <= {sw_raw, key_raw};
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            change_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i]   <= '0;
                state_q[i] <= STABLE;
            end
        end else begin
            level_q   <= level_d;
            press_q   <= toggle[NUM_KEYS-1:0] & level_d[NUM_KEYS-1:0];
            release_q <= toggle[NUM_KEYS-1:0] & ~level_d[NUM_KEYS-1:0];
            change_q  <= |toggle[N-1:NUM_KEYS];
            for (int i = 0; i < N; i++) begin
                cnt_q[i]   <= cnt_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    always_comb begin
        logic [CW-1:0] cur;
        level_d = level_q;
        cur     = '0;
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            // The counter is held at zero while STABLE, so only trust it while COUNTING.
            cur = (state_q[i] == COUNTING) ? cnt_q[i] : '0;
            if (synced[i] == level_q[i]) begin
                cnt_d[i]   = '0;
                state_d[i] = STABLE;
            end else if (cur == CNT_LAST) begin
                level_d[i] = ~level_q[i];
                cnt_d[i]   = '0;
                state_d[i] = STABLE;
            end else begin
                cnt_d[i]   = cur + 1'b1;
                state_d[i] = COUNTING;
            end
        end
    end

    assign toggle      = level_d ^ level_q;
    assign key_level   = level_q[NUM_KEYS-1:0];
    assign sw_level    = level_q[N-1:NUM_KEYS];
    assign key_press   = press_q;
    assign key_release = release_q;
    assign sw_change   = change_q;

endmodule
